// File: rtl/ftoi.sv
// ftoi: two-stage binary32 -> signed int32 converter.
// Stage 1 classifies the exponent and works out the shift amount.
// Stage 2 shifts, rounds (nearest, ties away from zero), negates and
// saturates. Valid-tagged stream, one operand per cycle, no backpressure.
module ftoi (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stage1_valid,
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        valid
);

    // Exponent thresholds in biased form:
    // 126 = 2^-1, 150 = mantissa LSB weighs 1, 158 = 2^31.
    localparam logic [7:0] E_HALF = 8'd126;
    localparam logic [7:0] E_UNIT = 8'd150;
    localparam logic [7:0] E_SAT  = 8'd158;

    // Valid shift register: [0] is stage 1 (v1), [1] drives the valid output.
    logic [1:0]  vld_pipe_q;

    // Stage 1 state.
    logic        s_q,    s_d;
    logic [23:0] m_q,    m_d;
    logic        zero_q, zero_d;
    logic        sat_q,  sat_d;
    logic        lsh_q,  lsh_d;
    logic        rsh_q,  rsh_d;
    logic [4:0]  sh_q,   sh_d;

    // Stage 2 state.
    logic [31:0] y_q, y_d;

    logic [7:0]  e;
    logic [22:0] f;
    logic [7:0]  lsh_amt;
    logic [7:0]  rsh_amt;
    logic [24:0] rsh_ext;
    logic [31:0] mag;

    assign e       = x[30:23];
    assign f       = x[22:0];
    assign lsh_amt = e - E_UNIT;
    assign rsh_amt = E_UNIT - e;

    // Stage 1 decode: classify the operand and pick the shift direction.
    // NaN folds into the positive saturation path by forcing the sign to 0.
    // The exact -2^31 case lands on negative saturation, which is the same
    // bit pattern, so it needs no separate flag.
    always_comb begin
        s_d    = x[31];
        m_d    = {1'b1, f};
        zero_d = 1'b0;
        sat_d  = 1'b0;
        lsh_d  = 1'b0;
        rsh_d  = 1'b0;
        sh_d   = 5'd0;
        if (e == 8'hFF && f != 23'd0) begin
            sat_d = 1'b1;
            s_d   = 1'b0;
        end else if (e >= E_SAT) begin
            sat_d = 1'b1;
        end else if (e >= E_UNIT) begin
            lsh_d = 1'b1;
            sh_d  = lsh_amt[4:0];
        end else if (e >= E_HALF) begin
            rsh_d = 1'b1;
            sh_d  = rsh_amt[4:0];
        end else begin
            zero_d = 1'b1;
        end
    end

    // Stage 2 datapath. The mantissa is extended by one guard bit before
    // the right shift so the last bit shifted out lands in rsh_ext[0];
    // adding it to the truncated value gives round-half-away on magnitude.
    always_comb begin
        rsh_ext = {m_q, 1'b0} >> sh_q;
        mag     = 32'd0;
        if (lsh_q)
            mag = {8'd0, m_q} << sh_q[2:0];
        else if (rsh_q)
            mag = {8'd0, rsh_ext[24:1]} + {31'd0, rsh_ext[0]};

        y_d = s_q ? (32'd0 - mag) : mag;
        if (sat_q)
            y_d = s_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else if (zero_q)
            y_d = 32'd0;
    end

    // Valid bits advance every edge regardless of data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            vld_pipe_q <= 2'b00;
        else
            vld_pipe_q <= {vld_pipe_q[0], stage1_valid};
    end

    // Stage 1 register: loads only on an accepted operand, otherwise holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q    <= 1'b0;
            m_q    <= 24'd0;
            zero_q <= 1'b0;
            sat_q  <= 1'b0;
            lsh_q  <= 1'b0;
            rsh_q  <= 1'b0;
            sh_q   <= 5'd0;
        end else if (stage1_valid) begin
            s_q    <= s_d;
            m_q    <= m_d;
            zero_q <= zero_d;
            sat_q  <= sat_d;
            lsh_q  <= lsh_d;
            rsh_q  <= rsh_d;
            sh_q   <= sh_d;
        end
    end

    // Stage 2 register: y keeps the last result while v1 is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            y_q <= 32'd0;
        else if (vld_pipe_q[0])
            y_q <= y_d;
    end

    assign y     = y_q;
    assign valid = vld_pipe_q[1];

endmodule

// File: tb/tb_ftoi.sv
// Bench for ftoi: directed spec vectors plus randomized operands checked
// against an arithmetic reference model and a two-deep delay model.
module tb_ftoi;

    logic        clk;
    logic        rstn;
    logic        stage1_valid;
    logic [31:0] x;
    logic [31:0] y;
    logic        valid;

    int checks = 0;
    int errors = 0;

    // Expected-state model: operand waiting in stage 1, and visible outputs.
    logic        pv1;
    logic [31:0] py1;
    logic        m_valid;
    logic [31:0] m_y;

    ftoi dut (
        .clk          (clk),
        .rstn         (rstn),
        .stage1_valid (stage1_valid),
        .x            (x),
        .y            (y),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = m * 2^(E-150), rounded half away from zero on the
    // magnitude, signed, then clamped to the int32 range.
    function automatic logic [31:0] ref_ftoi(input logic [31:0] v);
        int     ee;
        longint m, mag, sv;
        ee = int'(v[30:23]);
        m  = longint'({1'b1, v[22:0]});
        if (ee == 255 && v[22:0] != 23'd0) return 32'h7FFF_FFFF;
        if (ee < 126) return 32'd0;
        if (ee > 158)
            mag = 64'sd1 << 40;
        else if (ee >= 150)
            mag = m << (ee - 150);
        else
            mag = (m + (64'sd1 << (149 - ee))) >> (150 - ee);
        sv = v[31] ? -mag : mag;
        if (sv > 64'sd2147483647)  sv = 64'sd2147483647;
        if (sv < -64'sd2147483648) sv = -64'sd2147483648;
        return sv[31:0];
    endfunction

    task automatic check_out(input string tag);
        checks++;
        assert (valid === m_valid) else begin
            errors++;
            $error("FAIL %s valid got %b exp %b", tag, valid, m_valid);
        end
        checks++;
        assert (y === m_y) else begin
            errors++;
            $error("FAIL %s y got %h exp %h", tag, y, m_y);
        end
    endtask

    // One clock: present operand, advance the model at the edge, check at negedge.
    task automatic cyc(input logic v, input logic [31:0] xi, input logic [31:0] e,
                       input string tag);
        stage1_valid = v;
        x            = xi;
        @(posedge clk);
        m_valid = pv1;
        if (pv1) m_y = py1;
        pv1 = v;
        if (v) py1 = e;
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic model_reset();
        pv1     = 1'b0;
        py1     = 32'd0;
        m_valid = 1'b0;
        m_y     = 32'd0;
    endtask

    logic [31:0] dir_x [16];
    logic [31:0] dir_y [16];
    logic [31:0] rx;
    logic [7:0]  re;

    initial begin
        dir_x[0]  = 32'h447A0000; dir_y[0]  = 32'h000003E8;
        dir_x[1]  = 32'h3F800000; dir_y[1]  = 32'h00000001;
        dir_x[2]  = 32'h00000000; dir_y[2]  = 32'h00000000;
        dir_x[3]  = 32'h40200000; dir_y[3]  = 32'h00000003;
        dir_x[4]  = 32'hC0200000; dir_y[4]  = 32'hFFFFFFFD;
        dir_x[5]  = 32'h3F000000; dir_y[5]  = 32'h00000001;
        dir_x[6]  = 32'h3EFFFFFF; dir_y[6]  = 32'h00000000;
        dir_x[7]  = 32'h3FBFFFFF; dir_y[7]  = 32'h00000001;
        dir_x[8]  = 32'h4EFFFFFF; dir_y[8]  = 32'h7FFFFF80;
        dir_x[9]  = 32'h4F000000; dir_y[9]  = 32'h7FFFFFFF;
        dir_x[10] = 32'hCF000000; dir_y[10] = 32'h80000000;
        dir_x[11] = 32'hCF000001; dir_y[11] = 32'h80000000;
        dir_x[12] = 32'h7F800000; dir_y[12] = 32'h7FFFFFFF;
        dir_x[13] = 32'hFF800000; dir_y[13] = 32'h80000000;
        dir_x[14] = 32'h7FC00000; dir_y[14] = 32'h7FFFFFFF;
        dir_x[15] = 32'hFFC00000; dir_y[15] = 32'h7FFFFFFF;

        // Reset held for 3 cycles, then idle after release.
        model_reset();
        rstn = 1'b0; stage1_valid = 1'b0; x = 32'd0;
        repeat (3) begin
            @(negedge clk);
            check_out("reset");
        end
        rstn = 1'b1;
        repeat (3) cyc(1'b0, 32'hDEADBEEF, 32'd0, "idle");

        // Directed values back to back, then drain.
        for (int i = 0; i < 16; i++) cyc(1'b1, dir_x[i], dir_y[i], "directed");
        repeat (2) cyc(1'b0, 32'd0, 32'd0, "drain");

        // Gapped valid pattern 1,1,0,1,0,1; y must hold across gaps.
        cyc(1'b1, 32'h42F60000, 32'h0000007B, "pat");   // 123.0
        cyc(1'b1, 32'hC2F70000, 32'hFFFFFF84, "pat");   // -123.5
        cyc(1'b0, 32'h3F800000, 32'd0,        "pat");
        cyc(1'b1, 32'h4B000001, 32'h00800001, "pat");   // 8388609.0
        cyc(1'b0, 32'h40200000, 32'd0,        "pat");
        cyc(1'b1, 32'hBF400000, 32'hFFFFFFFF, "pat");   // -0.75
        repeat (3) cyc(1'b0, 32'd0, 32'd0, "pat_drain");

        // Async reset with operands in flight.
        cyc(1'b1, 32'h447A0000, 32'h000003E8, "inflight");
        stage1_valid = 1'b1;
        x            = 32'h40200000;
        #2 rstn = 1'b0;
        model_reset();
        #1 check_out("async_rst");
        stage1_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        check_out("rst_hold");
        repeat (3) cyc(1'b0, 32'd0, 32'd0, "post_rst");
        cyc(1'b1, 32'hC0200000, 32'hFFFFFFFD, "post_rst_op");
        repeat (3) cyc(1'b0, 32'd0, 32'd0, "post_rst_drain");

        // Randomized operands, biased toward the interesting exponent range.
        for (int i = 0; i < 400; i++) begin
            re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(120, 160));
            rx = {1'($urandom_range(0, 1)), re, 23'($urandom)};
            cyc($urandom_range(0, 3) != 0, rx, ref_ftoi(rx), "random");
        end
        repeat (2) cyc(1'b0, 32'd0, 32'd0, "final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ftoi.md
Name: ftoi

Overview:
- Pipelined FPU converter: IEEE-754 binary32 to signed 32-bit two's-complement integer. It is the inverse of the itof unit.
- Rounding is round-to-nearest with ties away from zero. Out-of-range inputs saturate.
- Sits in the FPU execute path beside itof, with the same valid-tagged streaming interface: no backpressure, one operation accepted per cycle.

Parameters:
- none (widths fixed at 32; latency fixed at 2 cycles)

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- stage1_valid  in  1  x carries a valid operand this cycle
- x  in  32  binary32 operand {s[31], e[30:23], f[22:0]}
- y  out  32  signed integer result (registered)
- valid  out  1  y holds the result of an accepted operand

Behaviour:
- Reset: asynchronous assertion when rstn=0 clears all pipeline registers, so y=0, valid=0 and both internal stage-valid bits are 0. Deassertion takes effect at the next clk edge.
- Reset mid-operation discards all in-flight operands. No valid pulse appears for them after release.
- Stage 1 register, loaded at a clk edge when stage1_valid=1:
  - captures s, the 24-bit mantissa m={1,f}, and the class flags zero/small, saturate, left-shift and right-shift;
  - computes the shift amount.
- Stage 1 valid bit (v1) captures stage1_valid on every edge.
- Stage 2 register, loaded when v1=1:
  - performs the shift and the rounding increment;
  - applies sign negation;
  - writes y.
- valid captures v1 on every edge.
- Latency: an operand sampled at edge N appears on y with valid=1 after edge N+2.
- Throughput is one operand per cycle. Back-to-back and gapped valid patterns are reproduced exactly, delayed by 2 cycles.
- When a stage's valid bit is 0, that stage's data register holds. So y keeps its last valid result while valid=0.
- Conversion rules, with E = e:
  - E < 126 (|x| < 0.5, including zero and denormals): y = 0. Negative inputs also give 0; there is no -0.
  - 126 <= E <= 149: magnitude = (m >> (150-E)) + r, where r is the last bit shifted out. Ties round away from zero. The magnitude never exceeds 2^24, so there is no overflow.
  - 150 <= E <= 157: magnitude = m << (E-150), exact, and always < 2^31.
  - E == 158 with s=1 and f=0: y = 0x80000000 (exact -2^31).
  - E >= 158 otherwise, including infinities: saturate. s=0 gives 0x7FFFFFFF; s=1 gives 0x80000000.
  - NaN (E=255, f!=0): y = 0x7FFFFFFF regardless of sign.
- Sign: y = s ? -magnitude : magnitude, computed as a 32-bit two's complement.
- The rounding increment is applied before negation, so the result is symmetric about zero.
- Behaviour is undefined if x is X while stage1_valid=1. x is ignored when stage1_valid=0.

Test Plan:
1. Reset held 3 cycles, then released with stage1_valid=0 -> y=0x00000000, valid=0 throughout; no spurious valid pulse.
2. Basic values on consecutive cycles, each result 2 cycles after its input:
   - 0x447A0000 (1000.0) -> y=0x000003E8;
   - 0x3F800000 (1.0) -> y=0x00000001;
   - 0x00000000 -> y=0x00000000.
3. Rounding:
   - 0x40200000 (2.5) -> 0x00000003;
   - 0xC0200000 (-2.5) -> 0xFFFFFFFD;
   - 0x3F000000 (0.5) -> 0x00000001;
   - 0x3EFFFFFF -> 0x00000000;
   - 0x3FBFFFFF (~1.49999) -> 0x00000001.
4. Range limits:
   - 0x4EFFFFFF -> 0x7FFFFF80;
   - 0x4F000000 -> 0x7FFFFFFF;
   - 0xCF000000 -> 0x80000000;
   - 0xCF000001 -> 0x80000000;
   - 0x7F800000 -> 0x7FFFFFFF;
   - 0xFF800000 -> 0x80000000;
   - 0x7FC00000 and 0xFFC00000 -> 0x7FFFFFFF.
5. Valid pattern: stage1_valid=1,1,0,1,0,1 with distinct operands:
   - valid must show 1,1,0,1,0,1 two cycles later, with the matching y values;
   - during valid=0 cycles, y holds the previous result.
6. Two valid operands in flight, then rstn pulsed low for half a cycle (asynchronous) -> y=0 and valid=0 immediately. Neither in-flight result ever appears. The next operand after release converts normally with 2-cycle latency.
